// File: rtl/alu_sequencer_if.sv
// Request/response bundle for alu_sequencer: operand request handshake plus result handshake and flags.
interface alu_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       sel;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] out;
   logic             carry;
   logic             ovr;

   modport master (
      output req_valid, a, b, sel, resp_ready,
      input  req_ready, resp_valid, out, carry, ovr
   );

   modport slave (
      input  req_valid, a, b, sel, resp_ready,
      output req_ready, resp_valid, out, carry, ovr
   );
endinterface

// File: rtl/alu_sequencer.sv
// Bit-serial ADD/SUB/AND/OR sequencer: one shared 1-bit cell, LSB first, one bit per clock.
// Optional macro ALU_SEQ_OVF_EN builds the signed-overflow register; otherwise ovr is tied to 0.
module alu_sequencer #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   alu_sequencer_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] out_reg;
   logic [1:0]       op;
   logic             cy;
   logic [CW-1:0]    count;
   logic             req_ready_reg;
   logic             resp_valid_reg;

   logic             ai;
   logic             bi;
   logic             bit_res;
   logic             cy_next;

   // Shared cell; for SUB the B operand is already inverted and the carry preset to 1.
   always_comb begin
      ai      = a_sh[0];
      bi      = b_sh[0];
      bit_res = 1'b0;
      cy_next = 1'b0;
      case (op)
         2'b00, 2'b01: begin
            bit_res = ai ^ bi ^ cy;
            cy_next = (ai & bi) | (cy & (ai ^ bi));
         end
         2'b10:   bit_res = ai & bi;
         default: bit_res = ai | bi;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         a_sh           <= '0;
         b_sh           <= '0;
         out_reg        <= '0;
         op             <= 2'b00;
         cy             <= 1'b0;
         count          <= '0;
         req_ready_reg  <= 1'b1;
         resp_valid_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid && req_ready_reg) begin
                  a_sh          <= bus.a;
                  b_sh          <= (bus.sel == 2'b01) ? ~bus.b : bus.b;
                  op            <= bus.sel;
                  cy            <= (bus.sel == 2'b01);
                  count         <= '0;
                  req_ready_reg <= 1'b0;
                  state         <= RUN;
               end
            end
            RUN: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               out_reg <= {bit_res, out_reg[WIDTH-1:1]};
               cy      <= cy_next;
               count   <= count + 1'b1;
               if (count == LAST) begin
                  state          <= DONE;
                  resp_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               // req_ready only reappears in the following cycle, so a result and a new request never share an edge.
               if (bus.resp_ready) begin
                  state          <= IDLE;
                  resp_valid_reg <= 1'b0;
                  req_ready_reg  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_OVF_EN
   logic ovr_reg;

   // Overflow is carry-in XOR carry-out of the MSB cell, captured while the last bit is processed.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovr_reg <= 1'b0;
      end else if (state == RUN && count == LAST) begin
         ovr_reg <= (op[1] == 1'b0) ? (cy ^ cy_next) : 1'b0;
      end
   end

   assign bus.ovr = ovr_reg;
`else
   assign bus.ovr = 1'b0;
`endif

   assign bus.req_ready  = req_ready_reg;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.out        = out_reg;
   assign bus.carry      = cy;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, multi-cycle corner sequences, randomized ops vs. arithmetic model.
module tb_alu_sequencer;
   localparam int WIDTH = 8;
`ifdef ALU_SEQ_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checkCount = 0;
   int   passCount  = 0;

   alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

   alu_sequencer #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string            name;
      logic [1:0]       sel;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] out;
      logic             carry;
      logic             ovr;
   } vec_t;

   vec_t vecs[9];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference computed from integer arithmetic on unsigned and signed operand values.
   function automatic void refModel(input logic [1:0] sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] res, output logic cout, output logic ov);
      int ua, ub, sa, sb, r, sr;
      ua   = int'(a);
      ub   = int'(b);
      sa   = ua - (a[WIDTH-1] ? (1 << WIDTH) : 0);
      sb   = ub - (b[WIDTH-1] ? (1 << WIDTH) : 0);
      res  = '0;
      cout = 1'b0;
      ov   = 1'b0;
      case (sel)
         2'b00: begin
            r    = ua + ub;
            res  = WIDTH'(r);
            cout = (r >= (1 << WIDTH));
            sr   = sa + sb;
            ov   = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
         end
         2'b01: begin
            r    = ua - ub;
            res  = WIDTH'(r);
            cout = (ua >= ub);
            sr   = sa - sb;
            ov   = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
         end
         2'b10: res = a & b;
         default: res = a | b;
      endcase
      ov = ov & OVF_EN;
   endfunction

   task automatic startOp(input string name, input logic [1:0] sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int lat;
      bus.req_valid = 1'b1;
      bus.a         = a;
      bus.b         = b;
      bus.sel       = sel;
      checkOutput({name, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.a         = WIDTH'($urandom);
      bus.b         = WIDTH'($urandom);
      bus.sel       = 2'($urandom);
      checkOutput({name, " req_ready run"}, 32'(bus.req_ready), 32'd0);
      lat = 0;
      while (bus.resp_valid !== 1'b1 && lat < 4 * WIDTH) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({name, " latency"}, 32'(lat), 32'(WIDTH));
   endtask

   task automatic finishOp(input string name, input logic [WIDTH-1:0] expOut, input logic expCarry, input logic expOvr,
                           input int holdCycles);
      checkOutput({name, " out"}, 32'(bus.out), 32'(expOut));
      checkOutput({name, " carry"}, 32'(bus.carry), 32'(expCarry));
      checkOutput({name, " ovr"}, 32'(bus.ovr), 32'(expOvr));
      repeat (holdCycles) @(negedge clk);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      checkOutput({name, " resp_valid after consume"}, 32'(bus.resp_valid), 32'd0);
      checkOutput({name, " req_ready after consume"}, 32'(bus.req_ready), 32'd1);
      checkOutput({name, " out held in idle"}, 32'(bus.out), 32'(expOut));
   endtask

   task automatic applyStimulus(input string name, input logic [1:0] sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] expOut, input logic expCarry, input logic expOvr, input int holdCycles);
      startOp(name, sel, a, b);
      finishOp(name, expOut, expCarry, expOvr, holdCycles);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [WIDTH-1:0] eo;
      logic             ec, ev;
      logic [1:0]       rs;
      logic [WIDTH-1:0] ra, rb;
      int               seen;

      vecs[0] = '{"add_02_02", 2'b00, 8'h02, 8'h02, 8'h04, 1'b0, 1'b0};
      vecs[1] = '{"add_ff_01", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{"add_7f_01", 2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, OVF_EN};
      vecs[3] = '{"add_80_80", 2'b00, 8'h80, 8'h80, 8'h00, 1'b1, OVF_EN};
      vecs[4] = '{"sub_05_07", 2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
      vecs[5] = '{"sub_07_05", 2'b01, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
      vecs[6] = '{"sub_80_01", 2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, OVF_EN};
      vecs[7] = '{"and_f0_3c", 2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
      vecs[8] = '{"or_f0_0c",  2'b11, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0};

      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.sel        = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset out", 32'(bus.out), 32'd0);
      checkOutput("reset carry", 32'(bus.carry), 32'd0);
      checkOutput("reset ovr", 32'(bus.ovr), 32'd0);
      checkOutput("reset resp_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("reset req_ready", 32'(bus.req_ready), 32'd1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].carry, vecs[i].ovr, i % 3);
      end

      // DONE held with resp_ready low while a new request and operands churn on the inputs.
      startOp("hold", 2'b00, 8'h7F, 8'h01);
      refModel(2'b00, 8'h7F, 8'h01, eo, ec, ev);
      for (int i = 0; i < 5; i++) begin
         bus.req_valid = 1'b1;
         bus.a         = WIDTH'($urandom);
         bus.b         = WIDTH'($urandom);
         @(negedge clk);
         checkOutput($sformatf("hold%0d out", i), 32'(bus.out), 32'(eo));
         checkOutput($sformatf("hold%0d carry", i), 32'(bus.carry), 32'(ec));
         checkOutput($sformatf("hold%0d ovr", i), 32'(bus.ovr), 32'(ev));
         checkOutput($sformatf("hold%0d req_ready", i), 32'(bus.req_ready), 32'd0);
         checkOutput($sformatf("hold%0d resp_valid", i), 32'(bus.resp_valid), 32'd1);
      end
      bus.resp_ready = 1'b1;
      bus.a          = 8'h11;
      bus.b          = 8'h22;
      bus.sel        = 2'b00;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      checkOutput("hold consume resp_valid", 32'(bus.resp_valid), 32'd0);
      applyStimulus("after_hold", 2'b01, 8'h30, 8'h05, 8'h2B, 1'b1, 1'b0, 0);

      // Reset landing on bit 3 of RUN, with req_valid high to show reset wins.
      bus.req_valid = 1'b1;
      bus.a         = 8'hAA;
      bus.b         = 8'h55;
      bus.sel       = 2'b00;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst           = 1'b1;
      bus.req_valid = 1'b1;
      @(negedge clk);
      rst           = 1'b0;
      bus.req_valid = 1'b0;
      checkOutput("abort out", 32'(bus.out), 32'd0);
      checkOutput("abort carry", 32'(bus.carry), 32'd0);
      checkOutput("abort ovr", 32'(bus.ovr), 32'd0);
      checkOutput("abort resp_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("abort req_ready", 32'(bus.req_ready), 32'd1);
      seen = 0;
      repeat (WIDTH + 2) begin
         @(negedge clk);
         if (bus.resp_valid === 1'b1) seen++;
      end
      checkOutput("abort no response", 32'(seen), 32'd0);
      applyStimulus("post_abort_add", 2'b00, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         rs = 2'($urandom_range(0, 3));
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         refModel(rs, ra, rb, eo, ec, ev);
         applyStimulus($sformatf("rand%0d", i), rs, ra, rb, eo, ec, ev, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
